// File: rtl/uart_pkg.sv
// Shared UART types: line FSM states, register map and status bit layout.
`timescale 1ns/1ps
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic UART_DATA   = 1'b0;
  localparam logic UART_STATUS = 1'b1;

  localparam int ST_AVAIL = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_FERR  = 2;
  localparam int ST_OVR   = 3;

endpackage

// File: rtl/uart_rx_fifo.sv
// Byte FIFO for received characters; head is visible combinationally.
`timescale 1ns/1ps
module uart_rx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);
  assign dout  = mem[rd_ptr];

  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with byte FIFO and DATA/STATUS read registers.
`timescale 1ns/1ps
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        RX_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic        addr_i,
  output logic [31:0] DATA_o,
  output logic        ready_o,
  output logic        rx_avail_o,
  output logic        frame_err_o,
  output logic        overrun_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);

  state_t        state;
  state_t        nxt;
  logic          sync1;
  logic          sync2;
  logic          prev;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;

  logic start_edge;
  logic tick;
  logic ld_half;
  logic ld_full;
  logic shift_en;
  logic push_req;
  logic ferr_set;

  logic        full;
  logic        empty;
  logic [7:0]  head;
  logic        rd;
  logic        rd_pop;
  logic        st_clr;
  logic        ovr_set;
  logic [31:0] status;
  logic [31:0] rdata;

  assign start_edge = ~sync2 & prev;
  assign tick       = (cnt == '0);

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
      state <= IDLE;
    end else begin
      sync1 <= RX_i;
      sync2 <= sync1;
      prev  <= sync2;
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  if (start_edge) nxt = START;
      START: if (tick) nxt = sync2 ? IDLE : DATA;
      DATA:  if (tick && bit_idx == 3'd7) nxt = STOP;
      STOP:  if (tick) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    ld_half  = (state == IDLE) & start_edge;
    ld_full  = tick & (((state == START) & ~sync2) | (state == DATA));
    shift_en = tick & (state == DATA);
    push_req = tick & (state == STOP) & sync2;
    ferr_set = tick & (state == STOP) & ~sync2;
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      if (ld_half)             cnt <= HALF_LOAD;
      else if (ld_full)        cnt <= FULL_LOAD;
      else if (state != IDLE)  cnt <= cnt - 1'b1;
      if (state == START) begin
        bit_idx <= '0;
      end else if (shift_en) begin
        shift[bit_idx] <= sync2;
        bit_idx        <= bit_idx + 1'b1;
      end
    end
  end

  uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .push  (push_req),
    .pop   (rd_pop),
    .din   (shift),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  assign rx_avail_o = ~empty;
  assign rd         = req_i & ~we_i;
  assign rd_pop     = rd & (addr_i == UART_DATA) & ~empty;
  assign st_clr     = rd & (addr_i == UART_STATUS);
  assign ovr_set    = push_req & full & ~rd_pop;

  always_comb begin
    status           = '0;
    status[ST_AVAIL] = ~empty;
    status[ST_FULL]  = full;
    status[ST_FERR]  = frame_err_o;
    status[ST_OVR]   = overrun_o;
    if (addr_i == UART_STATUS) rdata = status;
    else if (!empty)           rdata = {24'd0, head};
    else                       rdata = '0;
  end

  // A fresh error outranks the clear from a concurrent STATUS read.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      DATA_o      <= '0;
      ready_o     <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      ready_o     <= req_i;
      frame_err_o <= ferr_set | (frame_err_o & ~st_clr);
      overrun_o   <= ovr_set | (overrun_o & ~st_clr);
      if (rd) DATA_o <= rdata;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized scoreboard bench for uart_rx against a queue-based reference.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b1;
  logic        RX_i = 1'b1;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic        addr_i = 1'b0;
  logic [31:0] DATA_o;
  logic        ready_o;
  logic        rx_avail_o;
  logic        frame_err_o;
  logic        overrun_o;

  uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .CLOCK       (CLOCK),
    .RESET       (RESET),
    .RX_i        (RX_i),
    .req_i       (req_i),
    .we_i        (we_i),
    .addr_i      (addr_i),
    .DATA_o      (DATA_o),
    .ready_o     (ready_o),
    .rx_avail_o  (rx_avail_o),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o)
  );

  always #5 CLOCK = ~CLOCK;

  int checks = 0;
  int errors = 0;

  logic [31:0]  exp_q[$];
  logic [7:0]   m_fifo[$];
  bit           m_ferr = 0;
  bit           m_ovr = 0;
  logic [31:0]  m_last = '0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every ready pulse consumes one expected bus response.
  logic [31:0] mon_exp;
  always @(negedge CLOCK) begin
    if (!RESET && ready_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL ready_unexpected: ready_o=1 with no request pending");
      end else begin
        mon_exp = exp_q.pop_front();
        chk("read_data", DATA_o, mon_exp);
      end
    end
  end

  task automatic bus(input bit we, input bit addr);
    logic [31:0] e;
    @(posedge CLOCK); #1;
    req_i  = 1'b1;
    we_i   = we;
    addr_i = addr;
    if (!we) begin
      if (addr) begin
        e = {28'd0, m_ovr, m_ferr, m_fifo.size() == DEPTH, m_fifo.size() != 0};
        m_ovr  = 0;
        m_ferr = 0;
      end else if (m_fifo.size() != 0) begin
        e = {24'd0, m_fifo.pop_front()};
      end else begin
        e = '0;
      end
      m_last = e;
    end else begin
      e = m_last;
    end
    exp_q.push_back(e);
    @(posedge CLOCK); #1;
    req_i = 1'b0;
    we_i  = 1'b0;
    @(posedge CLOCK); #1;
    chk("ready_latency", exp_q.size(), 0);
    chk("ready_pulse", ready_o, 0);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit good);
    @(posedge CLOCK); #1;
    RX_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(posedge CLOCK);
      #1 RX_i = b[i];
    end
    repeat (CPB) @(posedge CLOCK);
    #1 RX_i = good;
    repeat (CPB - 4) @(posedge CLOCK);
    #1;
    if (good) begin
      if (m_fifo.size() == DEPTH) m_ovr = 1;
      else m_fifo.push_back(b);
    end else begin
      m_ferr = 1;
    end
    chk("rx_avail", rx_avail_o, m_fifo.size() != 0);
    chk("frame_err", frame_err_o, m_ferr);
    chk("overrun", overrun_o, m_ovr);
    repeat (4) @(posedge CLOCK);
    #1 RX_i = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLOCK);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rb;
    bit         rg;

    idle(3);
    chk("reset_data", DATA_o, 0);
    chk("reset_ready", ready_o, 0);
    chk("reset_avail", rx_avail_o, 0);
    chk("reset_ferr", frame_err_o, 0);
    chk("reset_ovr", overrun_o, 0);
    RESET = 1'b0;
    idle(4);

    // 1: basic byte
    send_frame(8'hA5, 1);
    bus(0, 0);
    chk("avail_after_pop", rx_avail_o, 0);

    // 2: short glitch is ignored
    @(posedge CLOCK); #1 RX_i = 1'b0;
    idle(4);
    RX_i = 1'b1;
    idle(3 * CPB);
    chk("glitch_avail", rx_avail_o, 0);
    send_frame(8'h3C, 1);
    bus(0, 0);

    // 3: framing error
    send_frame(8'h3C, 0);
    idle(CPB);
    bus(0, 1);
    bus(0, 1);

    // 4: overrun
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1);
    bus(0, 1);
    for (int i = 0; i < 5; i++) bus(0, 0);

    // 5: reset mid-frame, with state to clear
    send_frame(8'h77, 1);
    bus(0, 1);
    send_frame(8'h00, 0);
    idle(CPB);
    @(posedge CLOCK); #1 RX_i = 1'b0;
    repeat (CPB) @(posedge CLOCK);
    #1 RX_i = 1'b1;
    repeat (3 * CPB + CPB / 2) @(posedge CLOCK);
    #3 RESET = 1'b1;
    #1;
    chk("async_rst_data", DATA_o, 0);
    chk("async_rst_ready", ready_o, 0);
    chk("async_rst_avail", rx_avail_o, 0);
    chk("async_rst_ferr", frame_err_o, 0);
    chk("async_rst_ovr", overrun_o, 0);
    m_fifo.delete();
    m_ferr = 0;
    m_ovr  = 0;
    m_last = '0;
    idle(3);
    RESET = 1'b0;
    idle(6 * CPB);
    send_frame(8'h5A, 1);
    bus(0, 0);

    // 6: pop coinciding with push into a full FIFO
    for (int i = 0; i < 4; i++) send_frame(8'(8'h10 + i), 1);
    fork
      send_frame(8'h14, 1);
      begin
        repeat (154) @(posedge CLOCK);
        bus(0, 0);
      end
    join
    bus(0, 1);
    bus(1, 0);
    bus(0, 1);
    for (int i = 0; i < 4; i++) bus(0, 0);

    // random frames, stop bits and reads
    for (int n = 0; n < 10; n++) begin
      rb = 8'($urandom_range(0, 255));
      rg = ($urandom_range(0, 3) != 0);
      send_frame(rb, rg);
      idle($urandom_range(0, 20));
      if ($urandom_range(0, 1) == 1) bus(0, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) bus(1, 1'($urandom_range(0, 1)));
    end
    bus(0, 1);
    while (m_fifo.size() != 0) bus(0, 0);
    bus(0, 0);

    idle(4);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Serial UART receiver and memory-mapped read port; sits on the line side opposite the UART transmitter and consumes the 8N1 stream that block produces. It oversamples RX_i with a baud counter, reassembles bytes LSB-first and queues them in a small FIFO. It also exposes a data/status register pair to the core bus using the same req_i/we_i handshake as the transmitter.

Parameters:
CLKS_PER_BIT, 868, clock cycles per bit period (100 MHz / 115200); legal range >= 4.
FIFO_DEPTH, 4, received-byte FIFO entries; power of two, >= 2.

Ports:
CLOCK  input  1  system clock, rising edge
RESET  input  1  asynchronous, active-high reset
RX_i  input  1  serial line, idle high, 8N1, LSB first
req_i  input  1  bus request, one-cycle pulse
we_i  input  1  bus write enable; writes are ignored
addr_i  input  1  0 = DATA register, 1 = STATUS register
DATA_o  output  32  registered read data
ready_o  output  1  pulses 1 the cycle after any req_i
rx_avail_o  output  1  FIFO non-empty (interrupt source)
frame_err_o  output  1  sticky framing error
overrun_o  output  1  sticky overrun

Behaviour:
- Reset values: DATA_o=0, ready_o=0, rx_avail_o=0, frame_err_o=0, overrun_o=0; FIFO empty; state IDLE; both synchroniser flops=1; counters=0.
- RX_i passes through a 2-flop synchroniser, then an edge register. A start edge is sync=0 with the previous sample=1.
- FSM states (IDLE, START, DATA, STOP), width 2:
  - IDLE: on start edge -> START, baud counter = CLKS_PER_BIT/2-1.
  - START: counter==0 samples line. 0 -> DATA, counter=CLKS_PER_BIT-1, bit_idx=0. 1 (glitch) -> IDLE, nothing recorded.
  - DATA: counter==0 stores sample into shift[bit_idx] and reloads counter. After bit_idx 7 -> STOP; otherwise bit_idx++.
  - STOP: counter==0 samples line and always -> IDLE. 1 -> push byte. 0 -> discard byte, set frame_err.
- After a bad stop bit, a new frame starts only after the line returns high and falls again (edge rule).
- Counter width: $clog2(CLKS_PER_BIT). Counter decrements every cycle outside IDLE.
- Push when FIFO is full: byte dropped, overrun set, FIFO unchanged.
- Push and pop in the same cycle: both happen, occupancy unchanged. When full, the pop frees the slot and the push is accepted, with no overrun.
- Read data (req_i & ~we_i), registered, valid with ready_o one cycle later:
  - addr_i=0, FIFO non-empty: DATA_o={24'b0, head}, then pop.
  - addr_i=0, FIFO empty: DATA_o=0, no pop.
  - addr_i=1: DATA_o={28'b0, overrun, frame_err, full, avail}, i.e. bit0 avail, bit1 full, bit2 frame_err, bit3 overrun. The STATUS read clears both sticky bits.
  - A new error in the same cycle as a STATUS read: set wins, and the bit stays 1.
- Writes (req_i & we_i): no state change, DATA_o holds its value, ready_o still pulses.
- Outputs with no req_i: DATA_o holds its last value, ready_o=0.
- rx_avail_o is combinational from FIFO count != 0.
- RESET mid-frame aborts immediately to reset values; the partial byte is lost.

Decomposition:
- Package uart_pkg holds:
  - state enum (IDLE/START/DATA/STOP), shared with the transmitter;
  - register address constants UART_DATA=0, UART_STATUS=1;
  - status bit positions ST_AVAIL=0, ST_FULL=1, ST_FERR=2, ST_OVR=3.
- Sub-module uart_rx_fifo: synchronous FIFO with parameter DEPTH and width 8. Ports: push, pop, din, dout (head, combinational), full, empty. Same CLOCK/RESET. Pointers wrap modulo DEPTH; the count register is $clog2(DEPTH)+1 bits.

Test Plan (bench uses CLKS_PER_BIT=16, FIFO_DEPTH=4):
1. Drive byte 0xA5, 8N1 -> rx_avail_o=1 within 4 cycles of the stop-bit midpoint. DATA read gives DATA_o=0x000000A5 with ready_o=1 one cycle after req_i; rx_avail_o then returns to 0.
2. RX_i low for 4 cycles then high -> no push, rx_avail_o stays 0. A following frame 0x3C is received correctly.
3. Frame 0x3C with stop bit 0 -> no push, frame_err_o=1. STATUS read returns 0x4; a second STATUS read returns 0x0.
4. Five frames 0x01..0x05 with no reads -> STATUS=0xB. Four DATA reads return 0x01..0x04; a fifth returns 0x00000000.
5. Assert RESET during data bit 3 of 0xFF -> all outputs 0 asynchronously. After release, frame 0x5A is received as 0x5A.
6. Full FIFO, DATA read landing in the stop-bit push cycle -> no overrun, occupancy stays 4. A write with we_i=1 -> ready_o pulses and the FIFO is unchanged.
